modbus_poll_scheduler: RTL and testbench



---
 rtl/modbus_poll_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_modbus_poll_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_poll_scheduler.sv
// rtl/modbus_poll_scheduler.sv - round-robin scheduler sharing one modbus frame engine among SLOTS requesters
// Optional reply-timeout retry is enabled by defining MODBUS_SCHED_RETRY_EN.
module modbus_poll_scheduler #(
   parameter int SLOTS         = 4,
   parameter int FRAME_BYTES   = 8,
   parameter int RX_BUFFERSIZE = 64,
   parameter int ACK_TIMEOUT   = 120000,
   parameter int RX_TIMEOUT    = 120000,
   parameter int GAP_CYCLES    = 4800
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [SLOTS-1:0]              i_req,
   input  logic [SLOTS*8-1:0]            i_req_len,
   input  logic [SLOTS*FRAME_BYTES*8-1:0] i_req_data,
   output logic [SLOTS-1:0]              o_grant,
   output logic                          o_done,
   output logic [2:0]                    o_done_slot,
   output logic [1:0]                    o_status,
   output logic [7:0]                    o_resp_len,
   output logic [RX_BUFFERSIZE-25:0]     o_resp_data,
   output logic                          o_busy,
   output logic [FRAME_BYTES*8+15:0]     o_txdata,
   input  logic [RX_BUFFERSIZE-1:0]      i_rxdata
);

   localparam int PW  = FRAME_BYTES*8;
   localparam int TXW = PW+16;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_WAIT_ACK = 3'd2;
   localparam logic [2:0] S_WAIT_RX  = 3'd3;
   localparam logic [2:0] S_GAP      = 3'd4;

`ifdef MODBUS_SCHED_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic [2:0]               r_state;
   logic [2:0]               r_slot;
   logic [2:0]               r_rr;
   logic [7:0]               r_frame_id;
   logic [7:0]               r_rx_ref;
   logic [31:0]              r_cnt;
   logic [SLOTS-1:0]         r_grant;
   logic [TXW-1:0]           r_txdata;
   logic                     r_done;
   logic [2:0]               r_done_slot;
   logic [1:0]               r_status;
   logic [7:0]               r_resp_len;
   logic [RX_BUFFERSIZE-25:0] r_resp_data;
   logic                     r_retried;
   logic                     r_retry_pend;

   logic [2*SLOTS-1:0]       w_req2;
   logic [SLOTS-1:0]         w_rot;
   logic                     w_pick_found;
   logic [2:0]               w_pick_slot;
   logic [3:0]               w_sum;
   logic [PW-1:0]            w_payload;
   logic [7:0]               w_len_raw;
   logic [7:0]               w_len;
   logic                     w_ack;
   logic                     w_reply;
   logic                     w_end;
   logic                     w_retry;
   logic [1:0]               w_end_status;
   logic [2:0]               w_rr_next;

   // Rotate requests so bit 0 is the rr pointer; the lowest set rotated bit wins.
   assign w_req2 = {i_req, i_req} >> r_rr;
   assign w_rot  = w_req2[SLOTS-1:0];

   always_comb begin
      w_pick_found = 1'b0;
      w_pick_slot  = 3'd0;
      w_sum        = 4'd0;
      for (int i = SLOTS-1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_sum = {1'b0, r_rr} + 4'(i);
            if (w_sum >= 4'(SLOTS)) w_sum = w_sum - 4'(SLOTS);
            w_pick_found = 1'b1;
            w_pick_slot  = w_sum[2:0];
         end
      end
   end

   always_comb begin
      w_payload = '0;
      w_len_raw = 8'd0;
      for (int i = 0; i < SLOTS; i++) begin
         if (r_slot == 3'(i)) begin
            w_payload = i_req_data[i*PW +: PW];
            w_len_raw = i_req_len[i*8 +: 8];
         end
      end
   end

   assign w_len     = (w_len_raw > 8'(FRAME_BYTES)) ? 8'(FRAME_BYTES) : w_len_raw;
   assign w_ack     = (i_rxdata[7:0] == r_frame_id);
   assign w_reply   = (i_rxdata[15:8] != r_rx_ref);
   assign w_rr_next = (r_slot == 3'(SLOTS-1)) ? 3'd0 : r_slot + 3'd1;

   always_comb begin
      w_end        = 1'b0;
      w_retry      = 1'b0;
      w_end_status = 2'b00;
      if (r_state == S_WAIT_ACK && !w_ack && r_cnt == 32'(ACK_TIMEOUT-1)) begin
         w_end        = 1'b1;
         w_end_status = 2'b10;
      end else if (r_state == S_WAIT_RX) begin
         if (w_reply) begin
            w_end        = 1'b1;
            w_end_status = r_retried ? 2'b11 : 2'b00;
         end else if (r_cnt == 32'(RX_TIMEOUT-1)) begin
            if (RETRY_EN && !r_retried) begin
               w_retry = 1'b1;
            end else begin
               w_end        = 1'b1;
               w_end_status = 2'b01;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_slot       <= 3'd0;
         r_rr         <= 3'd0;
         r_frame_id   <= 8'd0;
         r_rx_ref     <= 8'd0;
         r_cnt        <= 32'd0;
         r_grant      <= '0;
         r_txdata     <= '0;
         r_done       <= 1'b0;
         r_done_slot  <= 3'd0;
         r_status     <= 2'b00;
         r_resp_len   <= 8'd0;
         r_resp_data  <= '0;
         r_retried    <= 1'b0;
         r_retry_pend <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pick_found) begin
                  r_slot    <= w_pick_slot;
                  r_grant   <= SLOTS'(1) << w_pick_slot;
                  r_rx_ref  <= i_rxdata[15:8];
                  r_retried <= 1'b0;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_frame_id <= r_frame_id + 8'd1;
               r_txdata   <= {w_payload, w_len, r_frame_id + 8'd1};
               r_cnt      <= 32'd0;
               r_state    <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (w_ack) begin
                  r_cnt   <= 32'd0;
                  r_state <= S_WAIT_RX;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_WAIT_RX: r_cnt <= r_cnt + 32'd1;
            S_GAP: begin
               if (r_cnt == 32'(GAP_CYCLES-1)) begin
                  r_state      <= r_retry_pend ? S_ISSUE : S_IDLE;
                  r_retry_pend <= 1'b0;
                  r_cnt        <= 32'd0;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_end) begin
            r_done      <= 1'b1;
            r_done_slot <= r_slot;
            r_status    <= w_end_status;
            r_grant     <= '0;
            r_rr        <= w_rr_next;
            r_cnt       <= 32'd0;
            r_state     <= S_GAP;
            if (r_state == S_WAIT_RX && w_reply) begin
               r_resp_len  <= i_rxdata[23:16];
               r_resp_data <= i_rxdata[RX_BUFFERSIZE-1:24];
            end
         end
         // Retry keeps the grant: the same slot re-issues after the gap.
         if (w_retry) begin
            r_retried    <= 1'b1;
            r_retry_pend <= 1'b1;
            r_cnt        <= 32'd0;
            r_state      <= S_GAP;
         end
      end
   end

   assign o_grant     = r_grant;
   assign o_done      = r_done;
   assign o_done_slot = r_done_slot;
   assign o_status    = r_status;
   assign o_resp_len  = r_resp_len;
   assign o_resp_data = r_resp_data;
   assign o_busy      = (r_state != S_IDLE);
   assign o_txdata    = r_txdata;

endmodule

// File: tb/tb_modbus_poll_scheduler.sv
// tb/tb_modbus_poll_scheduler.sv - directed bench for modbus_poll_scheduler with a behavioural frame engine
module tb_modbus_poll_scheduler;
   localparam int SLOTS = 4;
   localparam int FB    = 8;
   localparam int RXB   = 64;
   localparam int TO    = 1000;
   localparam int GAP   = 50;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req;
   logic [31:0]     req_len;
   logic [255:0]    req_data;
   logic [3:0]      grant;
   logic            done;
   logic [2:0]      done_slot;
   logic [1:0]      status;
   logic [7:0]      resp_len;
   logic [39:0]     resp_data;
   logic            busy;
   logic [79:0]     txdata;
   logic [63:0]     rxdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit          eng_ack_en   = 1'b1;
   bit          eng_reply_en = 1'b1;
   int          eng_skip_id  = -1;
   logic [7:0]  eng_rxlen    = 8'd2;
   logic [39:0] eng_payload  = 40'hBEEF;
   int          t_ack        = -1;

   modbus_poll_scheduler #(
      .SLOTS(SLOTS), .FRAME_BYTES(FB), .RX_BUFFERSIZE(RXB),
      .ACK_TIMEOUT(TO), .RX_TIMEOUT(TO), .GAP_CYCLES(GAP)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_len(req_len), .i_req_data(req_data),
      .o_grant(grant), .o_done(done), .o_done_slot(done_slot), .o_status(status),
      .o_resp_len(resp_len), .o_resp_data(resp_data), .o_busy(busy), .o_txdata(txdata),
      .i_rxdata(rxdata)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // Engine: starts on a txdata id change, acks 20 cycles later, replies 10 cycles after that.
   initial begin
      logic [7:0] last;
      int ack_cnt, rep_cnt;
      bit ack_pend, rep_pend;
      rxdata = '0; last = 8'd0; ack_pend = 0; rep_pend = 0; ack_cnt = 0; rep_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last = txdata[7:0]; rxdata[7:0] = 8'd0; ack_pend = 0; rep_pend = 0;
         end else if (txdata[7:0] != last) begin
            last = txdata[7:0]; ack_pend = 1; ack_cnt = 20; rep_pend = 0;
         end else if (ack_pend) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
               ack_pend = 0;
               if (eng_ack_en) begin
                  rxdata[7:0] = last;
                  t_ack = cyc;
                  if (eng_reply_en && int'(last) != eng_skip_id) begin
                     rep_pend = 1; rep_cnt = 10;
                  end
               end
            end
         end else if (rep_pend) begin
            rep_cnt--;
            if (rep_cnt == 0) begin
               rep_pend = 0;
               rxdata[15:8]  = rxdata[15:8] + 8'd1;
               rxdata[23:16] = eng_rxlen;
               rxdata[63:24] = eng_payload;
            end
         end
      end
   end

   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) ok = 1'b1;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL done_timeout got=none want=done within %0d cycles", budget);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 400) begin @(negedge clk); n++; end
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; req_len = '0; req_data = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({grant, done, busy, status, done_slot} !== 11'd0) begin
         bad++; $display("FAIL reset_ctrl got=%0h want=0", {grant, done, busy, status, done_slot});
      end
      total++;
      if ({txdata, resp_len, resp_data} !== '0) begin
         bad++; $display("FAIL reset_data got=%0h want=0", {txdata, resp_len, resp_data});
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      int n;
      req_len[7:0] = 8'd3; req_data[63:0] = 64'h030201;
      req = 4'b0001;
      @(negedge clk);
      total++;
      if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", grant); end
      wait_done(200, ok);
      total++;
      if (txdata !== {64'h030201, 8'h03, 8'h01}) begin
         bad++; $display("FAIL single_txdata got=%h want=%h", txdata, {64'h030201, 8'h03, 8'h01});
      end
      total++;
      if ({done_slot, status, resp_len} !== {3'd0, 2'b00, 8'd2}) begin
         bad++; $display("FAIL single_status got=%h want=%h", {done_slot, status, resp_len}, {3'd0, 2'b00, 8'd2});
      end
      total++;
      if (resp_data !== 40'hBEEF) begin bad++; $display("FAIL single_resp got=%h want=beef", resp_data); end
      req = 4'b0000;
      n = 0;
      while (busy && n < 200) begin @(negedge clk); n++; end
      total++;
      if (n !== GAP) begin bad++; $display("FAIL single_gap got=%0d want=%0d", n, GAP); end
   endtask

   task automatic test_round_robin();
      int exp_slot[5] = '{0, 1, 3, 0, 1};
      bit ok;
      int viol = 0;
      int n;
      logic [3:0] g;
      pulse_reset();
      req_len = {8'd1, 8'd1, 8'd1, 8'd1};
      req = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (grant == 4'b0000 && n < 100) begin @(negedge clk); n++; end
         g = grant;
         wait_done(300, ok);
         total++;
         if (done_slot !== 3'(exp_slot[k]) || g !== (4'b0001 << exp_slot[k])) begin
            bad++; $display("FAIL rr_slot[%0d] got=%0d/%b want=%0d", k, done_slot, g, exp_slot[k]);
         end
         total++;
         if (txdata[7:0] !== 8'(k+1)) begin
            bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, txdata[7:0], k+1);
         end
         for (int j = 0; j < GAP-1; j++) begin
            @(negedge clk);
            if (grant !== 4'b0000) viol++;
         end
      end
      total++;
      if (viol !== 0) begin bad++; $display("FAIL rr_gap_grant got=%0d want=0", viol); end
      req = 4'b0000;
      wait_idle();
   endtask

   task automatic test_ack_timeout();
      bit ok;
      int n = 0;
      int t0;
      pulse_reset();
      eng_ack_en = 1'b0;
      req = 4'b0100;
      while (txdata[7:0] !== 8'd1 && n < 100) begin @(negedge clk); n++; end
      t0 = cyc;
      wait_done(1200, ok);
      total++;
      if (cyc - t0 !== TO) begin bad++; $display("FAIL ackto_time got=%0d want=%0d", cyc - t0, TO); end
      total++;
      if ({done_slot, status} !== {3'd2, 2'b10}) begin
         bad++; $display("FAIL ackto_status got=%h want=%h", {done_slot, status}, {3'd2, 2'b10});
      end
      eng_ack_en = 1'b1;
      wait_done(300, ok);
      total++;
      if ({txdata[7:0], status} !== {8'd2, 2'b00}) begin
         bad++; $display("FAIL ackto_next got=%h want=%h", {txdata[7:0], status}, {8'd2, 2'b00});
      end
      req = 4'b0000;
      wait_idle();
   endtask

   task automatic test_rx_timeout();
      bit ok;
      req = 4'b0001;
`ifdef MODBUS_SCHED_RETRY_EN
      eng_skip_id = 3;
      wait_done(2600, ok);
      total++;
      if ({txdata[7:0], status} !== {8'd4, 2'b11}) begin
         bad++; $display("FAIL retry_status got=%h want=%h", {txdata[7:0], status}, {8'd4, 2'b11});
      end
      eng_skip_id = -1;
`else
      eng_reply_en = 1'b0;
      wait_done(1300, ok);
      total++;
      if (cyc - t_ack - 1 !== TO) begin bad++; $display("FAIL rxto_time got=%0d want=%0d", cyc - t_ack - 1, TO); end
      total++;
      if ({txdata[7:0], status} !== {8'd3, 2'b01}) begin
         bad++; $display("FAIL rxto_status got=%h want=%h", {txdata[7:0], status}, {8'd3, 2'b01});
      end
      eng_reply_en = 1'b1;
`endif
      req = 4'b0000;
      wait_idle();
   endtask

   task automatic test_reset_mid();
      bit ok;
      int pre = t_ack;
      int n = 0;
      eng_reply_en = 1'b0;
      req = 4'b0001;
      while (t_ack == pre && n < 200) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({grant, busy, done, txdata} !== '0) begin
         bad++; $display("FAIL rstmid_clear got=%h want=0", {grant, busy, done, txdata});
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      eng_reply_en = 1'b1;
      wait_done(300, ok);
      total++;
      if ({txdata[7:0], status} !== {8'd1, 2'b00}) begin
         bad++; $display("FAIL rstmid_next got=%h want=%h", {txdata[7:0], status}, {8'd1, 2'b00});
      end
      req = 4'b0000;
      wait_idle();
   endtask

   task automatic test_wrap_clamp();
      bit ok;
      int ok_cnt = 0;
      pulse_reset();
      req_len[15:8]    = 8'd12;
      req_data[127:64] = 64'h8877665544332211;
      req = 4'b0010;
      for (int k = 0; k < 256; k++) begin
         wait_done(300, ok);
         if (ok && status == 2'b00) ok_cnt++;
         if (k == 0) begin
            total++;
            if (txdata[79:8] !== {64'h8877665544332211, 8'd8}) begin
               bad++; $display("FAIL clamp_len got=%h want=%h", txdata[79:8], {64'h8877665544332211, 8'd8});
            end
         end
         if (k == 254 || k == 255) begin
            total++;
            if (txdata[7:0] !== 8'(k+1)) begin
               bad++; $display("FAIL wrap_id[%0d] got=%0d want=%0d", k, txdata[7:0], 8'(k+1));
            end
         end
      end
      total++;
      if (ok_cnt !== 256) begin bad++; $display("FAIL wrap_ok got=%0d want=256", ok_cnt); end
      req = 4'b0000;
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ack_timeout();
      test_rx_timeout();
      test_reset_mid();
      test_wrap_clamp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
